store_cntrl: RTL and testbench

// - MEM-stage store path, write-side counterpart of the load extractor.
// - Takes a store (address, rs2 data, size) from the pipeline, places the data in byte lanes
//   and generates byte enables.
// - Issues one or two word writes to data memory over a req/gnt handshake.
// - Splits a misaligned store that crosses a word boundary into two word accesses.
// - Holds the pipeline via st_ready_o while busy.

---
 rtl/store_cntrl_if.sv | 64 ++++++
 rtl/store_cntrl.sv | 165 ++++++++++++++++
 tb/tb_store_cntrl.sv | 296 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/store_cntrl_if.sv
// rtl/store_cntrl_if.sv - store request and data-memory write bus bundle for store_cntrl
//
// Purpose: groups the pipeline store handshake, the data-memory req/gnt write bus
//          and the status pulses of store_cntrl into one bundle.
// Signals:
//   st_valid_i / st_ready_o   store handshake (accepted when both are 1)
//   st_addr_i  [31:0]         byte address of the store
//   st_data_i  [31:0]         rs2 data, LSB-aligned
//   st_size_i  [1:0]          00=SB 01=SH 10=SW 11=illegal
//   dmem_req_o / dmem_gnt_i   memory write handshake
//   dmem_addr_o [31:0]        word address (bits [1:0] always 00)
//   dmem_wdata_o [31:0]       lane-positioned write data
//   dmem_be_o [3:0]           byte enables
//   st_done_o                 pulse: last access of a store granted
//   misalign_o                pulse: word-crossing store rejected
//   size_err_o                pulse: illegal size rejected
// Modports: slave = store_cntrl side, master = pipeline/memory side.
interface store_cntrl_if;
   logic        st_valid_i;
   logic        st_ready_o;
   logic [31:0] st_addr_i;
   logic [31:0] st_data_i;
   logic [1:0]  st_size_i;
   logic        dmem_req_o;
   logic        dmem_gnt_i;
   logic [31:0] dmem_addr_o;
   logic [31:0] dmem_wdata_o;
   logic [3:0]  dmem_be_o;
   logic        st_done_o;
   logic        misalign_o;
   logic        size_err_o;

   modport slave (
      input  st_valid_i,
      output st_ready_o,
      input  st_addr_i,
      input  st_data_i,
      input  st_size_i,
      output dmem_req_o,
      input  dmem_gnt_i,
      output dmem_addr_o,
      output dmem_wdata_o,
      output dmem_be_o,
      output st_done_o,
      output misalign_o,
      output size_err_o
   );

   modport master (
      output st_valid_i,
      input  st_ready_o,
      output st_addr_i,
      output st_data_i,
      output st_size_i,
      input  dmem_req_o,
      output dmem_gnt_i,
      input  dmem_addr_o,
      input  dmem_wdata_o,
      input  dmem_be_o,
      input  st_done_o,
      input  misalign_o,
      input  size_err_o
   );
endinterface

// File: rtl/store_cntrl.sv
// rtl/store_cntrl.sv - MEM-stage store path: byte-lane placement, byte enables, split word writes
//
// Purpose: accepts a store (address, rs2 data, size) from the pipeline, positions the
//          data in byte lanes, generates byte enables and issues one or two word
//          writes to data memory over a req/gnt handshake. A store that crosses a
//          word boundary is split into two accesses (or rejected when
//          ALLOW_MISALIGNED=0). The pipeline is held off via st_ready_o while busy.
// Parameters:
//   ALLOW_MISALIGNED  1: split word-crossing stores, 0: reject them on misalign_o
// Ports:
//   clk_i    core clock
//   rst_ni   asynchronous active-low reset
//   bus      store_cntrl_if.slave (store handshake, dmem write bus, status pulses)
module store_cntrl #(
   parameter int unsigned ALLOW_MISALIGNED = 1
) (
   input  logic          clk_i,
   input  logic          rst_ni,
   store_cntrl_if.slave  bus
);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_REQ0 = 2'd1;
   localparam logic [1:0] S_REQ1 = 2'd2;

   localparam bit SPLIT_EN = (ALLOW_MISALIGNED != 0);

   logic [1:0]  state_q;
   logic        ready_q;
   logic        req_q;
   logic [31:0] addr_q;
   logic [31:0] wdata_q;
   logic [3:0]  be_q;
   logic        done_q;
   logic        misalign_q;
   logic        size_err_q;

   // Second-half data of a split store, captured at accept.
   logic        split_q;
   logic [3:0]  hi_be_q;
   logic [31:0] hi_wdata_q;

   logic [1:0]  off;
   logic [3:0]  mask;
   logic [31:0] data_m;
   logic        crosses;
   logic [7:0]  wide_be;
   logic [63:0] wide_wd;

   // Lane placement over an 8-byte window so a crossing store's upper part lands
   // in [7:4]/[63:32]. Data is truncated to the access size first so lanes outside
   // the byte enables are driven as zeros.
   always_comb begin
      off     = bus.st_addr_i[1:0];
      mask    = 4'b0000;
      data_m  = 32'h0000_0000;
      crosses = 1'b0;
      case (bus.st_size_i)
         2'b00: begin
            mask   = 4'b0001;
            data_m = {24'h00_0000, bus.st_data_i[7:0]};
         end
         2'b01: begin
            mask    = 4'b0011;
            data_m  = {16'h0000, bus.st_data_i[15:0]};
            crosses = (off == 2'b11);
         end
         2'b10: begin
            mask    = 4'b1111;
            data_m  = bus.st_data_i;
            crosses = (off != 2'b00);
         end
         default: begin
            mask   = 4'b0000;
            data_m = 32'h0000_0000;
         end
      endcase
      wide_be = {4'b0000, mask} << off;
      wide_wd = {32'h0000_0000, data_m} << {off, 3'b000};
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q    <= S_IDLE;
         ready_q    <= 1'b1;
         req_q      <= 1'b0;
         addr_q     <= 32'h0000_0000;
         wdata_q    <= 32'h0000_0000;
         be_q       <= 4'b0000;
         done_q     <= 1'b0;
         misalign_q <= 1'b0;
         size_err_q <= 1'b0;
         split_q    <= 1'b0;
         hi_be_q    <= 4'b0000;
         hi_wdata_q <= 32'h0000_0000;
      end else begin
         done_q     <= 1'b0;
         misalign_q <= 1'b0;
         size_err_q <= 1'b0;
         case (state_q)
            S_IDLE: begin
               if (bus.st_valid_i) begin
                  if (bus.st_size_i == 2'b11) begin
                     size_err_q <= 1'b1;
                  end else if (crosses && !SPLIT_EN) begin
                     misalign_q <= 1'b1;
                  end else begin
                     state_q    <= S_REQ0;
                     ready_q    <= 1'b0;
                     req_q      <= 1'b1;
                     addr_q     <= {bus.st_addr_i[31:2], 2'b00};
                     be_q       <= wide_be[3:0];
                     wdata_q    <= wide_wd[31:0];
                     split_q    <= crosses;
                     hi_be_q    <= wide_be[7:4];
                     hi_wdata_q <= wide_wd[63:32];
                  end
               end
            end
            S_REQ0: begin
               if (bus.dmem_gnt_i) begin
                  if (split_q) begin
                     // Address wraps naturally at 2^32.
                     state_q <= S_REQ1;
                     addr_q  <= addr_q + 32'd4;
                     be_q    <= hi_be_q;
                     wdata_q <= hi_wdata_q;
                  end else begin
                     state_q <= S_IDLE;
                     ready_q <= 1'b1;
                     req_q   <= 1'b0;
                     be_q    <= 4'b0000;
                     done_q  <= 1'b1;
                  end
               end
            end
            S_REQ1: begin
               if (bus.dmem_gnt_i) begin
                  state_q <= S_IDLE;
                  ready_q <= 1'b1;
                  req_q   <= 1'b0;
                  be_q    <= 4'b0000;
                  done_q  <= 1'b1;
               end
            end
            default: begin
               state_q <= S_IDLE;
               ready_q <= 1'b1;
               req_q   <= 1'b0;
               be_q    <= 4'b0000;
            end
         endcase
      end
   end

   assign bus.st_ready_o   = ready_q;
   assign bus.dmem_req_o   = req_q;
   assign bus.dmem_addr_o  = addr_q;
   assign bus.dmem_wdata_o = wdata_q;
   assign bus.dmem_be_o    = be_q;
   assign bus.st_done_o    = done_q;
   assign bus.misalign_o   = misalign_q;
   assign bus.size_err_o   = size_err_q;

endmodule

// File: tb/tb_store_cntrl.sv
// tb/tb_store_cntrl.sv - scoreboard testbench for store_cntrl
module tb_store_cntrl;

   localparam int K_BEAT = 0;
   localparam int K_DONE = 1;
   localparam int K_SERR = 2;

   typedef struct {
      int          kind;
      logic [31:0] addr;
      logic [3:0]  be;
      logic [31:0] wd;
      int          stall;
      int          lat;
   } ev_t;

   logic clk_i;
   logic rst_ni;

   store_cntrl_if sif ();
   store_cntrl_if mif ();

   store_cntrl #(.ALLOW_MISALIGNED(1)) u_dut (
      .clk_i  (clk_i),
      .rst_ni (rst_ni),
      .bus    (sif.slave)
   );

   store_cntrl #(.ALLOW_MISALIGNED(0)) u_dut_nomis (
      .clk_i  (clk_i),
      .rst_ni (rst_ni),
      .bus    (mif.slave)
   );

   ev_t exp_q[$];
   int  checks = 0;
   int  errors = 0;
   int  cyc = 0;
   int  acc_cyc = 0;

   initial clk_i = 1'b0;
   always #5 clk_i = ~clk_i;

   initial forever begin
      @(posedge clk_i);
      cyc++;
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic fail(input string name);
      checks++;
      errors++;
      $display("FAIL %s: event not expected or bound expired", name);
   endtask

   function automatic ev_t beat(input logic [31:0] a, input logic [3:0] be,
                                input logic [31:0] wd, input int stall);
      ev_t e;
      e.kind = K_BEAT; e.addr = a; e.be = be; e.wd = wd; e.stall = stall; e.lat = 0;
      return e;
   endfunction

   function automatic ev_t evt(input int kind, input int lat);
      ev_t e;
      e.kind = kind; e.addr = 32'h0; e.be = 4'h0; e.wd = 32'h0; e.stall = 0; e.lat = lat;
      return e;
   endfunction

   // Monitor and grant responder: gnt is decided at the negedge from the stall
   // count of the expected beat; a granted beat is compared against the queue.
   initial begin
      int          wait_cnt;
      logic        held_v;
      logic [31:0] held_addr;
      logic [31:0] held_wd;
      logic [3:0]  held_be;
      ev_t         e;
      wait_cnt = 0;
      held_v   = 1'b0;
      forever begin
         @(negedge clk_i);
         if (!rst_ni) begin
            sif.dmem_gnt_i = 1'b0;
            wait_cnt = 0;
            held_v   = 1'b0;
         end else begin
            if (sif.st_done_o) begin
               chk("ready_in_done_cycle", {31'h0, sif.st_ready_o}, 32'd1);
               if (exp_q.size() == 0 || exp_q[0].kind != K_DONE) fail("done_unexpected");
               else begin
                  e = exp_q.pop_front();
                  chk("done_latency", cyc - acc_cyc, e.lat);
               end
            end
            if (sif.size_err_o) begin
               chk("ready_in_err_cycle", {31'h0, sif.st_ready_o}, 32'd1);
               if (exp_q.size() == 0 || exp_q[0].kind != K_SERR) fail("size_err_unexpected");
               else e = exp_q.pop_front();
            end
            if (sif.misalign_o) fail("misalign_unexpected");
            if (sif.dmem_req_o) begin
               chk("ready_low_busy", {31'h0, sif.st_ready_o}, 32'd0);
               if (held_v) begin
                  chk("stall_addr_stable", sif.dmem_addr_o, held_addr);
                  chk("stall_be_stable", {28'h0, sif.dmem_be_o}, {28'h0, held_be});
                  chk("stall_wdata_stable", sif.dmem_wdata_o, held_wd);
               end
               if (exp_q.size() == 0 || exp_q[0].kind != K_BEAT) begin
                  fail("req_unexpected");
                  sif.dmem_gnt_i = 1'b1;
                  held_v = 1'b0;
               end else if (wait_cnt < exp_q[0].stall) begin
                  sif.dmem_gnt_i = 1'b0;
                  wait_cnt++;
                  held_v    = 1'b1;
                  held_addr = sif.dmem_addr_o;
                  held_be   = sif.dmem_be_o;
                  held_wd   = sif.dmem_wdata_o;
               end else begin
                  sif.dmem_gnt_i = 1'b1;
                  e = exp_q.pop_front();
                  chk("beat_addr", sif.dmem_addr_o, e.addr);
                  chk("beat_be", {28'h0, sif.dmem_be_o}, {28'h0, e.be});
                  chk("beat_wdata", sif.dmem_wdata_o, e.wd);
                  wait_cnt = 0;
                  held_v   = 1'b0;
               end
            end else begin
               sif.dmem_gnt_i = 1'b0;
               held_v = 1'b0;
               chk("be_zero_when_idle", {28'h0, sif.dmem_be_o}, 32'd0);
            end
         end
      end
   end

   task automatic issue(input logic [31:0] a, input logic [31:0] d, input logic [1:0] sz);
      int n;
      n = 0;
      @(negedge clk_i);
      sif.st_valid_i = 1'b1;
      sif.st_addr_i  = a;
      sif.st_data_i  = d;
      sif.st_size_i  = sz;
      while (!sif.st_ready_o && n < 200) begin
         @(negedge clk_i);
         n++;
      end
      if (n >= 200) fail("accept_timeout");
      @(negedge clk_i);
      acc_cyc = cyc;
      sif.st_valid_i = 1'b0;
   endtask

   task automatic drain();
      int n;
      n = 0;
      while (exp_q.size() != 0 && n < 100) begin
         @(negedge clk_i);
         n++;
      end
      if (exp_q.size() != 0) begin
         fail("drain_timeout");
         exp_q.delete();
      end
      @(negedge clk_i);
   endtask

   initial begin
      int n;
      int mis_seen;
      int req_seen;
      rst_ni = 1'b0;
      sif.st_valid_i = 1'b0; sif.st_addr_i = 32'h0; sif.st_data_i = 32'h0;
      sif.st_size_i = 2'b00; sif.dmem_gnt_i = 1'b0;
      mif.st_valid_i = 1'b0; mif.st_addr_i = 32'h0; mif.st_data_i = 32'h0;
      mif.st_size_i = 2'b00; mif.dmem_gnt_i = 1'b1;
      repeat (3) @(negedge clk_i);
      chk("rst_req", {31'h0, sif.dmem_req_o}, 32'd0);
      chk("rst_addr", sif.dmem_addr_o, 32'h0);
      chk("rst_wdata", sif.dmem_wdata_o, 32'h0);
      chk("rst_be", {28'h0, sif.dmem_be_o}, 32'd0);
      chk("rst_pulses", {29'h0, sif.st_done_o, sif.misalign_o, sif.size_err_o}, 32'd0);
      chk("rst_ready", {31'h0, sif.st_ready_o}, 32'd1);
      rst_ni = 1'b1;
      @(negedge clk_i);

      exp_q.push_back(beat(32'h0000_0100, 4'b1111, 32'hDEAD_BEEF, 0));
      exp_q.push_back(evt(K_DONE, 1));
      issue(32'h0000_0100, 32'hDEAD_BEEF, 2'b10);
      drain();

      exp_q.push_back(beat(32'h0000_0200, 4'b1000, 32'hA500_0000, 0));
      exp_q.push_back(evt(K_DONE, 1));
      issue(32'h0000_0203, 32'h0000_00A5, 2'b00);
      drain();

      exp_q.push_back(beat(32'h0000_0300, 4'b1100, 32'h1234_0000, 0));
      exp_q.push_back(evt(K_DONE, 1));
      issue(32'h0000_0302, 32'h0000_1234, 2'b01);
      drain();

      exp_q.push_back(beat(32'h0000_0400, 4'b1110, 32'h2233_4400, 0));
      exp_q.push_back(beat(32'h0000_0404, 4'b0001, 32'h0000_0011, 0));
      exp_q.push_back(evt(K_DONE, 2));
      issue(32'h0000_0401, 32'h1122_3344, 2'b10);
      drain();

      exp_q.push_back(beat(32'h0000_0000, 4'b1000, 32'hEF00_0000, 3));
      exp_q.push_back(beat(32'h0000_0004, 4'b0001, 32'h0000_00BE, 3));
      exp_q.push_back(evt(K_DONE, 8));
      issue(32'h0000_0003, 32'h0000_BEEF, 2'b01);
      drain();

      exp_q.push_back(beat(32'hFFFF_FFFC, 4'b1000, 32'hEF00_0000, 3));
      exp_q.push_back(beat(32'h0000_0000, 4'b0001, 32'h0000_00BE, 3));
      exp_q.push_back(evt(K_DONE, 8));
      issue(32'hFFFF_FFFF, 32'h0000_BEEF, 2'b01);
      drain();

      exp_q.push_back(evt(K_SERR, 0));
      issue(32'h0000_0500, 32'h1234_5678, 2'b11);
      drain();

      // Back-to-back stores; upper rs2 bytes must not leak into lanes.
      exp_q.push_back(beat(32'h0000_0004, 4'b1000, 32'h5A00_0000, 0));
      exp_q.push_back(evt(K_DONE, 1));
      exp_q.push_back(beat(32'h0000_0010, 4'b0011, 32'h0000_CAFE, 0));
      exp_q.push_back(evt(K_DONE, 1));
      issue(32'h0000_0007, 32'hFFFF_FF5A, 2'b00);
      issue(32'h0000_0010, 32'hABCD_CAFE, 2'b01);
      drain();

      // Misaligned SW on the non-splitting instance.
      @(negedge clk_i);
      mif.st_valid_i = 1'b1;
      mif.st_addr_i  = 32'h0000_0002;
      mif.st_data_i  = 32'h5566_7788;
      mif.st_size_i  = 2'b10;
      mis_seen = 0;
      req_seen = 0;
      @(negedge clk_i);
      mif.st_valid_i = 1'b0;
      for (int i = 0; i < 4; i++) begin
         if (mif.misalign_o) mis_seen++;
         if (mif.dmem_req_o) req_seen++;
         @(negedge clk_i);
      end
      chk("nomis_misalign_pulses", mis_seen, 1);
      chk("nomis_no_req", req_seen, 0);

      // Reset while the second half is waiting for grant.
      exp_q.push_back(beat(32'h0000_0400, 4'b1110, 32'h2233_4400, 0));
      exp_q.push_back(beat(32'h0000_0404, 4'b0001, 32'h0000_0011, 1000));
      issue(32'h0000_0401, 32'h1122_3344, 2'b10);
      n = 0;
      while (!(sif.dmem_req_o && sif.dmem_addr_o == 32'h0000_0404) && n < 50) begin
         @(negedge clk_i);
         n++;
      end
      if (n >= 50) fail("reach_req1_timeout");
      #1;
      rst_ni = 1'b0;
      #1;
      chk("midrst_req", {31'h0, sif.dmem_req_o}, 32'd0);
      chk("midrst_addr", sif.dmem_addr_o, 32'h0);
      chk("midrst_wdata", sif.dmem_wdata_o, 32'h0);
      chk("midrst_be", {28'h0, sif.dmem_be_o}, 32'd0);
      exp_q.delete();
      @(negedge clk_i);
      rst_ni = 1'b1;
      @(negedge clk_i);
      chk("postrst_ready", {31'h0, sif.st_ready_o}, 32'd1);
      chk("postrst_req", {31'h0, sif.dmem_req_o}, 32'd0);

      repeat (2) @(negedge clk_i);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: simulation did not complete");
      errors++;
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $fatal(1, "timeout");
   end

endmodule
